// File: rtl/result_display.sv
// result_display: shows the 8-bit result of the add/subtract unit in decimal
// on a 4-digit, active-low seven-segment display.
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   result_i   result word to display (captured on load)
//   signed_i   1 = result_i is two's complement
//   load       capture request, honoured only in IDLE
//   busy       high during the 8 double-dabble cycles
//   done       one-cycle pulse when the display registers are updated
//   an         digit enables, active-low (an[0] ones ... an[3] sign)
//   seg        segments, active-low (seg[0]=a .. seg[6]=g, seg[7]=dp)
module result_display #(
  parameter int REFRESH_BITS = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] result_i,
  input  logic       signed_i,
  input  logic       load,
  output logic       busy,
  output logic       done,
  output logic [3:0] an,
  output logic [7:0] seg
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [7:0]  mag_q, mag_d;
  logic [11:0] bcd_q, bcd_d;
  logic        neg_q;

  // display registers, only written on the CONV->DONE transition
  logic [3:0]  dh_q, dt_q, do_q;
  logic        dneg_q;

  logic [REFRESH_BITS-1:0] scan_q;
  logic [3:0]  an_q, an_d;
  logic [7:0]  seg_q, seg_d;
  logic [1:0]  sel;

  function automatic logic [3:0] dabble_adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // one double-dabble step: adjust each nibble, then shift {bcd,mag} left
  always_comb begin
    bcd_d = 12'd0;
    mag_d = 8'd0;
    {bcd_d, mag_d} = {dabble_adj(bcd_q[11:8]), dabble_adj(bcd_q[7:4]),
                      dabble_adj(bcd_q[3:0]), mag_q} << 1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      mag_q   <= 8'd0;
      bcd_q   <= 12'd0;
      neg_q   <= 1'b0;
      dh_q    <= 4'd0;
      dt_q    <= 4'd0;
      do_q    <= 4'd0;
      dneg_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (load) begin
          cnt_q   <= 3'd0;
          bcd_q   <= 12'd0;
          // magnitude of 0x80 signed is 128, which still fits in 8 bits
          if (signed_i && result_i[7]) begin
            mag_q <= ~result_i + 8'd1;
            neg_q <= 1'b1;
          end else begin
            mag_q <= result_i;
            neg_q <= 1'b0;
          end
          state_q <= CONV;
        end
        CONV: begin
          bcd_q <= bcd_d;
          mag_q <= mag_d;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            dh_q    <= bcd_d[11:8];
            dt_q    <= bcd_d[7:4];
            do_q    <= bcd_d[3:0];
            dneg_q  <= neg_q;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == CONV);
  assign done = (state_q == DONE);

  // display scan
  assign sel = scan_q[REFRESH_BITS-1 -: 2];

  always_comb begin
    an_d  = ~(4'b0001 << sel);
    seg_d = 8'hFF;
    case (sel)
      2'd0: seg_d = seg7(do_q);
      2'd1: seg_d = (dh_q == 4'd0 && dt_q == 4'd0) ? 8'hFF : seg7(dt_q);
      2'd2: seg_d = (dh_q == 4'd0) ? 8'hFF : seg7(dh_q);
      2'd3: seg_d = dneg_q ? 8'hBF : 8'hFF;
      default: seg_d = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_q <= '0;
      an_q   <= 4'b1111;
      seg_q  <= 8'hFF;
    end else begin
      scan_q <= scan_q + 1'b1;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_result_display.sv
module tb_result_display;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] result_i = 8'h00;
  logic       signed_i = 1'b0;
  logic       load = 1'b0;
  logic       busy, done;
  logic [3:0] an;
  logic [7:0] seg;

  int checks = 0;
  int errors = 0;

  result_display #(.REFRESH_BITS(4)) dut (
    .clk(clk), .rst(rst), .result_i(result_i), .signed_i(signed_i),
    .load(load), .busy(busy), .done(done), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] digit_code(input int d);
    logic [7:0] tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                             8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    return tbl[d];
  endfunction

  // expected segment patterns per position: [0]=ones [1]=tens [2]=hundreds [3]=sign
  logic [7:0] exp_disp [4];

  task automatic model(input logic [7:0] r, input logic s);
    int v, h, t, o;
    bit neg;
    neg = s && r[7];
    v   = neg ? 256 - int'(r) : int'(r);
    h   = v / 100;
    t   = (v / 10) % 10;
    o   = v % 10;
    exp_disp[0] = digit_code(o);
    exp_disp[1] = (h == 0 && t == 0) ? 8'hFF : digit_code(t);
    exp_disp[2] = (h == 0) ? 8'hFF : digit_code(h);
    exp_disp[3] = neg ? 8'hBF : 8'hFF;
  endtask

  // watch a full 16-cycle scan and compare each position with exp_disp
  task automatic scan_check(input string tag);
    logic [7:0] got [4];
    bit bad_an;
    for (int i = 0; i < 4; i++) got[i] = 8'hxx;
    bad_an = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      case (an)
        4'b1110: got[0] = seg;
        4'b1101: got[1] = seg;
        4'b1011: got[2] = seg;
        4'b0111: got[3] = seg;
        default: bad_an = 1;
      endcase
    end
    check({tag, "_an_onehot"}, 32'(bad_an), 32'd0);
    check({tag, "_ones"}, 32'(got[0]), 32'(exp_disp[0]));
    check({tag, "_tens"}, 32'(got[1]), 32'(exp_disp[1]));
    check({tag, "_hund"}, 32'(got[2]), 32'(exp_disp[2]));
    check({tag, "_sign"}, 32'(got[3]), 32'(exp_disp[3]));
  endtask

  // load one value and check busy/done timing; optionally re-pulse load mid-CONV
  task automatic do_load(input string tag, input logic [7:0] r, input logic s, input bit again);
    @(negedge clk);
    result_i = r;
    signed_i = s;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_done_lo"}, 32'(done), 32'd0);
      load = (again && k == 3);
      @(negedge clk);
    end
    load = 1'b0;
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_done_pulse"}, 32'(done), 32'd1);
    @(negedge clk);
    check({tag, "_done_once"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    model(r, s);
    scan_check(tag);
  endtask

  initial begin
    logic [7:0] rr;
    logic       ss;

    // reset held while clock runs
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b1;
    model(8'h00, 1'b0);
    scan_check("rst_disp");

    do_load("u_ff", 8'hFF, 1'b0, 0);
    do_load("s_f9", 8'hF9, 1'b1, 0);
    do_load("s_80", 8'h80, 1'b1, 0);
    do_load("u_80", 8'h80, 1'b0, 0);
    do_load("u_0a", 8'h0A, 1'b0, 0);
    do_load("reload", 8'h7B, 1'b1, 1);

    // changing result_i without load leaves the display alone
    result_i = 8'h33;
    signed_i = 1'b1;
    scan_check("noload");

    // abort: reset in the 4th CONV cycle
    @(negedge clk);
    result_i = 8'hFF;
    signed_i = 1'b0;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_pre", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_an", 32'(an), 32'hF);
    check("abort_seg", 32'(seg), 32'hFF);
    @(negedge clk);
    rst = 1'b1;
    model(8'h00, 1'b0);
    scan_check("abort_disp");
    do_load("u_2a", 8'h2A, 1'b0, 0);

    // randomized values against the model
    for (int n = 0; n < 10; n++) begin
      rr = 8'($urandom_range(0, 255));
      ss = 1'($urandom_range(0, 1));
      do_load("rand", rr, ss, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
